// File: rtl/pcpu_mem_loader_if.sv
// Host byte port plus instruction/data memory write ports and CPU control of the loader.
// The loader uses the slave view; the host/bench side drives through master.
interface pcpu_mem_loader_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          i_we;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_wdata;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          cpu_enable;
    logic          cpu_start;
    logic          busy;
    logic          err;
    logic [AW:0]   word_cnt;

    modport master (
        output in_valid, in_data,
        input  in_ready, i_we, i_addr, i_wdata, d_we, d_addr, d_wdata,
               cpu_enable, cpu_start, busy, err, word_cnt
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, i_we, i_addr, i_wdata, d_we, d_addr, d_wdata,
               cpu_enable, cpu_start, busy, err, word_cnt
    );
endinterface

// File: rtl/pcpu_mem_loader.sv
// Framed byte-stream loader: writes DW-bit words into I/D memory, holds the CPU off
// while loading, and releases it with a one-cycle start pulse on a GO command.
module pcpu_mem_loader #(
    parameter int         AW    = 8,
    parameter int         DW    = 16,
    parameter logic [7:0] CMD_I = 8'h49,
    parameter logic [7:0] CMD_D = 8'h44,
    parameter logic [7:0] CMD_G = 8'h47
) (
    input logic             clk,
    input logic             rst,
    pcpu_mem_loader_if.slave ld_if
);
    localparam int NB = DW / 8;
    localparam int KW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [2:0] {S_CMD, S_ADDR, S_CNT, S_DATA, S_WRITE, S_GO} state_t;

    state_t        state_q, state_d;
    logic          tgt_d_q, tgt_d_d;     // 1: data memory, 0: instruction memory
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   rem_q, rem_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [DW-1:0] word_q, word_d;
    logic [KW-1:0] k_q, k_d;
    logic          en_q, en_d;
    logic          err_q, err_d;
    logic [AW-1:0] ia_q, ia_d, da_q, da_d;
    logic [DW-1:0] iw_q, iw_d, dw_q, dw_d;
    logic          ready;
    logic          accept;
    logic [DW-1:0] shifted;

    assign ready   = (state_q != S_WRITE) && (state_q != S_GO);
    assign accept  = ld_if.in_valid && ready;
    assign shifted = {word_q[DW-9:0], ld_if.in_data};

    always_comb begin
        state_d = state_q;
        tgt_d_d = tgt_d_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        k_d     = k_q;
        en_d    = en_q;
        err_d   = err_q;
        ia_d    = ia_q;
        iw_d    = iw_q;
        da_d    = da_q;
        dw_d    = dw_q;
        case (state_q)
            S_CMD: if (accept) begin
                if (ld_if.in_data == CMD_I || ld_if.in_data == CMD_D) begin
                    tgt_d_d = (ld_if.in_data == CMD_D);
                    en_d    = 1'b0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_ADDR;
                end else if (ld_if.in_data == CMD_G) begin
                    err_d   = 1'b0;
                    state_d = S_GO;
                end else begin
                    err_d   = 1'b1;
                end
            end
            S_ADDR: if (accept) begin
                addr_d  = AW'(ld_if.in_data);
                state_d = S_CNT;
            end
            S_CNT: if (accept) begin
                // A zero count means a full 2^AW-word image.
                rem_d   = (ld_if.in_data == 8'h00) ? {1'b1, {AW{1'b0}}} : (AW+1)'(ld_if.in_data);
                k_d     = '0;
                state_d = S_DATA;
            end
            S_DATA: if (accept) begin
                word_d = shifted;
                if (k_q == KW'(NB - 1)) begin
                    k_d     = '0;
                    state_d = S_WRITE;
                    // Address/data registers only move on a write so they hold between strobes.
                    if (tgt_d_q) begin
                        da_d = addr_q;
                        dw_d = shifted;
                    end else begin
                        ia_d = addr_q;
                        iw_d = shifted;
                    end
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_WRITE: begin
                addr_d  = addr_q + AW'(1);
                cnt_d   = cnt_q + (AW+1)'(1);
                rem_d   = rem_q - (AW+1)'(1);
                state_d = (rem_q == (AW+1)'(1)) ? S_CMD : S_DATA;
            end
            S_GO: begin
                en_d    = 1'b1;
                state_d = S_CMD;
            end
            default: state_d = S_CMD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_CMD;
            tgt_d_q <= 1'b0;
            addr_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            k_q     <= '0;
            en_q    <= 1'b0;
            err_q   <= 1'b0;
            ia_q    <= '0;
            iw_q    <= '0;
            da_q    <= '0;
            dw_q    <= '0;
        end else begin
            state_q <= state_d;
            tgt_d_q <= tgt_d_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            k_q     <= k_d;
            en_q    <= en_d;
            err_q   <= err_d;
            ia_q    <= ia_d;
            iw_q    <= iw_d;
            da_q    <= da_d;
            dw_q    <= dw_d;
        end
    end

    assign ld_if.in_ready   = ready;
    assign ld_if.i_we       = (state_q == S_WRITE) && !tgt_d_q;
    assign ld_if.d_we       = (state_q == S_WRITE) &&  tgt_d_q;
    assign ld_if.i_addr     = ia_q;
    assign ld_if.i_wdata    = iw_q;
    assign ld_if.d_addr     = da_q;
    assign ld_if.d_wdata    = dw_q;
    assign ld_if.cpu_enable = en_q;
    assign ld_if.cpu_start  = (state_q == S_GO);
    assign ld_if.busy       = (state_q != S_CMD);
    assign ld_if.err        = err_q;
    assign ld_if.word_cnt   = cnt_q;
endmodule
